// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the CPU memory-bus initiator (mem_ctrl).
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_TURN
    } state_t;

    localparam logic [1:0] IO_SEL         = 2'b11;
    localparam int         RAM_ADDR_WIDTH = 17;

    // Encoding 2'b11 is not a legal size; it is sequenced as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size_t'(size))
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side request/response signals plus the 8-bit system bus seen by mem_ctrl.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              rdy_in;
    logic              if_req_in;
    logic [31:0]       if_addr_in;
    logic              if_flush_in;
    logic              if_done_out;
    logic [31:0]       if_data_out;
    logic              ls_req_in;
    logic              ls_wr_in;
    logic [1:0]        ls_size_in;
    logic              ls_signed_in;
    logic [31:0]       ls_addr_in;
    logic [31:0]       ls_wdata_in;
    logic              ls_done_out;
    logic [31:0]       ls_rdata_out;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  rdy_in, if_req_in, if_addr_in, if_flush_in,
               ls_req_in, ls_wr_in, ls_size_in, ls_signed_in, ls_addr_in, ls_wdata_in,
               mem_din,
        output if_done_out, if_data_out, ls_done_out, ls_rdata_out,
               mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy_in, if_req_in, if_addr_in, if_flush_in,
               ls_req_in, ls_wr_in, ls_size_in, ls_signed_in, ls_addr_in, ls_wdata_in,
               mem_din,
        input  if_done_out, if_data_out, ls_done_out, ls_rdata_out,
               mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl_load_ext.sv
// Byte-lane merge of the incoming read byte and sign/zero extension of the result.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] buf_word,
    input  logic [7:0]  din,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_en,
    output logic [31:0] merged,
    output logic [31:0] data
);
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = (lane == 2'(gi)) ? din : buf_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        data = merged;
        case (size_t'(size))
            SZ_B:    data = {{24{sign_en & merged[7]}}, merged[7:0]};
            SZ_H:    data = {{16{sign_en & merged[15]}}, merged[15:0]};
            default: data = merged;
        endcase
    end
endmodule

// File: rtl/mem_ctrl.sv
// CPU memory-bus initiator: serialises fetch and load/store requests into byte accesses.
// Define MEM_PERF_CNT_EN to add the perf_busy_out / perf_stall_out cycle counters.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IO_SEL_HI = 17
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    mem_ctrl_if.slave   bus
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_busy_out,
    output logic [31:0] perf_stall_out
`endif
);
    state_t            state_reg;
    logic              port_ls_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        size_reg;
    logic              sign_reg;
    logic [31:0]       wdata_reg;
    logic [2:0]        issue_reg;
    logic [2:0]        recv_reg;
    logic              pending_reg;
    logic [31:0]       buf_reg;
    logic              if_done_reg;
    logic              ls_done_reg;
    logic [31:0]       if_data_reg;
    logic [31:0]       ls_data_reg;

    logic [2:0]  nbytes;
    logic        drive_read;
    logic        drive_write;
    logic        capture;
    logic        last_capture;
    logic        fetch_flush;
    logic [31:0] merged;
    logic [31:0] ext_data;

    generate
        if (IO_SEL_HI < 1 || IO_SEL_HI >= ADDR_W) begin : g_bad_io_sel
            $error("IO_SEL_HI must select two bits inside the address");
        end
    endgenerate

    assign nbytes       = size_bytes(size_reg);
    assign drive_read   = (state_reg == ST_READ) && bus.rdy_in && (issue_reg < nbytes);
    assign drive_write  = (state_reg == ST_WRITE) && bus.rdy_in;
    // pending_reg marks a byte addressed last cycle whose data is on mem_din now
    assign capture      = (state_reg == ST_READ) && bus.rdy_in && pending_reg;
    assign last_capture = capture && ((recv_reg + 3'd1) == nbytes);
    assign fetch_flush  = (state_reg == ST_READ) && !port_ls_reg && bus.if_flush_in;

    assign bus.mem_a    = (drive_read || drive_write) ? addr_reg + ADDR_W'(issue_reg) : '0;
    assign bus.mem_wr   = drive_write;
    assign bus.mem_dout = drive_write ? wdata_reg[{issue_reg[1:0], 3'b000} +: 8] : 8'h00;

    assign bus.if_done_out  = if_done_reg;
    assign bus.if_data_out  = if_data_reg;
    assign bus.ls_done_out  = ls_done_reg;
    assign bus.ls_rdata_out = ls_data_reg;

    mem_load_ext u_load_ext (
        .buf_word (buf_reg),
        .din      (bus.mem_din),
        .lane     (recv_reg[1:0]),
        .size     (size_reg),
        .sign_en  (sign_reg),
        .merged   (merged),
        .data     (ext_data)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg   <= ST_IDLE;
            port_ls_reg <= 1'b0;
            addr_reg    <= '0;
            size_reg    <= '0;
            sign_reg    <= 1'b0;
            wdata_reg   <= '0;
            issue_reg   <= '0;
            recv_reg    <= '0;
            pending_reg <= 1'b0;
            buf_reg     <= '0;
            if_done_reg <= 1'b0;
            ls_done_reg <= 1'b0;
            if_data_reg <= '0;
            ls_data_reg <= '0;
        end else begin
            if_done_reg <= 1'b0;
            ls_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: if (bus.rdy_in) begin
                    if (bus.ls_req_in) begin
                        state_reg   <= bus.ls_wr_in ? ST_WRITE : ST_READ;
                        port_ls_reg <= 1'b1;
                        addr_reg    <= ADDR_W'(bus.ls_addr_in);
                        size_reg    <= bus.ls_size_in;
                        sign_reg    <= bus.ls_signed_in;
                        wdata_reg   <= bus.ls_wdata_in;
                    end else if (bus.if_req_in && !bus.if_flush_in) begin
                        state_reg   <= ST_READ;
                        port_ls_reg <= 1'b0;
                        addr_reg    <= ADDR_W'(bus.if_addr_in);
                        size_reg    <= SZ_W;
                        sign_reg    <= 1'b0;
                    end
                    issue_reg   <= '0;
                    recv_reg    <= '0;
                    pending_reg <= 1'b0;
                    buf_reg     <= '0;
                end
                ST_READ: begin
                    if (fetch_flush) begin
                        state_reg   <= ST_IDLE;
                        pending_reg <= 1'b0;
                    end else if (!bus.rdy_in) begin
                        // The byte in flight is lost while the bus is lent; re-issue it.
                        issue_reg   <= recv_reg;
                        pending_reg <= 1'b0;
                    end else begin
                        pending_reg <= drive_read;
                        if (drive_read) issue_reg <= issue_reg + 3'd1;
                        if (capture) begin
                            buf_reg  <= merged;
                            recv_reg <= recv_reg + 3'd1;
                        end
                        if (last_capture) begin
                            state_reg <= ST_TURN;
                            if (port_ls_reg) begin
                                ls_done_reg <= 1'b1;
                                ls_data_reg <= ext_data;
                            end else begin
                                if_done_reg <= 1'b1;
                                if_data_reg <= ext_data;
                            end
                        end
                    end
                end
                ST_WRITE: if (bus.rdy_in) begin
                    issue_reg <= issue_reg + 3'd1;
                    if ((issue_reg + 3'd1) == nbytes) begin
                        state_reg   <= ST_TURN;
                        ls_done_reg <= 1'b1;
                    end
                end
                ST_TURN: if (bus.rdy_in) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] busy_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else if (state_reg != ST_IDLE) begin
            if (bus.rdy_in) busy_cnt_reg  <= busy_cnt_reg + 32'd1;
            else            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign perf_busy_out  = busy_cnt_reg;
    assign perf_stall_out = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-array memory model, per-cycle done/data checks.
module tb_mem_ctrl;
    import mem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_if bus ();

`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_busy;
    logic [31:0] perf_stall;
    mem_ctrl dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus),
                  .perf_busy_out(perf_busy), .perf_stall_out(perf_stall));
`else
    mem_ctrl dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));
`endif

    function automatic logic [7:0] init_byte(input logic [12:0] a);
        case (a)
            13'h100: return 8'h11;
            13'h101: return 8'h22;
            13'h102: return 8'h33;
            13'h103: return 8'h44;
            13'h205: return 8'h80;
            13'h300: return 8'h01;
            13'h301: return 8'h80;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Responder RAM: read data appears one cycle after the address.
    logic [7:0] ram [0:8191];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8192; i++) ram[i] <= init_byte(13'(i));
        end else if (bus.rdy_in && bus.mem_wr) begin
            ram[bus.mem_a[12:0]] <= bus.mem_dout;
        end
        bus.mem_din <= ram[bus.mem_a[12:0]];
    end

    // Reference memory: the architectural byte contents the CPU should see.
    logic [7:0] model_mem [0:8191];

    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input bit sg);
        logic [31:0] w;
        logic [12:0] idx;
        int n;
        n = nb(sz);
        w = '0;
        for (int k = 0; k < n; k++) begin
            idx = 13'(a + 32'(k));
            w[8*k +: 8] = model_mem[idx];
        end
        if (sg && n < 4 && w[8*n-1]) w = w - (32'd1 << (8*n));
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Expected done cycles and data, set by the stimulus from the timing rules.
    int          exp_if_cyc = -1;
    int          exp_ls_cyc = -1;
    logic [31:0] exp_if_data = '0;
    logic [31:0] exp_ls_data = '0;
    bit          exp_ls_load = 1'b0;
    logic [31:0] hold_if = '0;
    logic [31:0] hold_ls = '0;
    bit          ls_hold_known = 1'b1;

    logic [31:0] tr_a  [0:1023];
    logic        tr_wr [0:1023];
    logic [7:0]  tr_d  [0:1023];

    always @(negedge clk) begin
        tr_a[cyc % 1024]  = bus.mem_a;
        tr_wr[cyc % 1024] = bus.mem_wr;
        tr_d[cyc % 1024]  = bus.mem_dout;
        if (chk_en) begin
            chk("if_done", 32'(bus.if_done_out), 32'(cyc == exp_if_cyc));
            if (cyc == exp_if_cyc) begin
                chk("if_data", bus.if_data_out, exp_if_data);
                hold_if = exp_if_data;
            end else begin
                chk("if_hold", bus.if_data_out, hold_if);
            end
            chk("ls_done", 32'(bus.ls_done_out), 32'(cyc == exp_ls_cyc));
            if (cyc == exp_ls_cyc) begin
                if (exp_ls_load) begin
                    chk("ls_data", bus.ls_rdata_out, exp_ls_data);
                    hold_ls = exp_ls_data;
                    ls_hold_known = 1'b1;
                end else begin
                    ls_hold_known = 1'b0;
                end
            end else if (ls_hold_known) begin
                chk("ls_hold", bus.ls_rdata_out, hold_ls);
            end
            if (!bus.rdy_in) chk("wr_in_stall", 32'(bus.mem_wr), 32'd0);
        end
    end

    // Issue one request at the current cycle T; rdy_in is low for cycles T+s0 .. T+s0+sl-1.
    task automatic do_req(input bit ls, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input int s0, input int sl, output logic [31:0] got, output int t);
        bit seen;
        int rel;
        t = cyc;
        if (ls) begin
            exp_ls_cyc  = t + lat;
            exp_ls_load = !wr;
            exp_ls_data = exp_load(a, sz, sg);
            bus.ls_wr_in = wr;  bus.ls_size_in = sz;  bus.ls_signed_in = sg;
            bus.ls_addr_in = a; bus.ls_wdata_in = wd;  bus.ls_req_in = 1'b1;
        end else begin
            exp_if_cyc  = t + lat;
            exp_if_data = exp_load(a, 2'b10, 1'b0);
            bus.if_addr_in = a; bus.if_req_in = 1'b1;
        end
        seen = 1'b0;
        got  = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            rel = cyc - t;
            bus.rdy_in = !(sl > 0 && rel >= s0 && rel < s0 + sl);
            @(negedge clk);
            seen = ls ? bus.ls_done_out : bus.if_done_out;
            got  = ls ? bus.ls_rdata_out : bus.if_data_out;
        end
        chk("done_seen", 32'(seen), 32'd1);
        bus.ls_req_in = 1'b0;
        bus.if_req_in = 1'b0;
        if (ls && wr) begin
            for (int k = 0; k < nb(sz); k++) model_mem[13'(a + 32'(k))] = wd[8*k +: 8];
        end
        @(posedge clk); #1;
        bus.rdy_in = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] got, got_ls;
        int t;
        bit seen;
        for (int i = 0; i < 8192; i++) model_mem[i] = init_byte(13'(i));
        bus.rdy_in = 1'b1;      bus.if_req_in = 1'b0;  bus.if_addr_in = '0;  bus.if_flush_in = 1'b0;
        bus.ls_req_in = 1'b0;   bus.ls_wr_in = 1'b0;   bus.ls_size_in = '0;  bus.ls_signed_in = 1'b0;
        bus.ls_addr_in = '0;    bus.ls_wdata_in = '0;

        // Reset state
        #12;
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst_if_done", 32'(bus.if_done_out), 32'd0);
        chk("rst_if_data", bus.if_data_out, 32'd0);
        chk("rst_ls_done", 32'(bus.ls_done_out), 32'd0);
        chk("rst_ls_data", bus.ls_rdata_out, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fetch word 0x100: addresses T+1..T+4, done T+6
        do_req(0, 0, 2'b10, 0, 32'h100, 0, 6, 0, 0, got, t);
        chk("fetch_lit", got, 32'h44332211);
        for (int k = 0; k < 4; k++) chk("fetch_addr", tr_a[(t+1+k) % 1024], 32'h100 + 32'(k));
        chk("fetch_bus_idle", tr_a[(t+5) % 1024], 32'd0);

        // Loads: byte signed/unsigned, signed half
        do_req(1, 0, 2'b00, 1, 32'h205, 0, 3, 0, 0, got, t);
        chk("lb_signed_lit", got, 32'hFFFFFF80);
        do_req(1, 0, 2'b00, 0, 32'h205, 0, 3, 0, 0, got, t);
        chk("lb_unsigned_lit", got, 32'h00000080);
        do_req(1, 0, 2'b01, 1, 32'h300, 0, 4, 0, 0, got, t);
        chk("lh_signed_lit", got, 32'hFFFF8001);

        // Store word: mem_wr for T+1..T+4, done T+5
        do_req(1, 1, 2'b10, 0, 32'h1000, 32'hDEADBEEF, 5, 0, 0, got, t);
        for (int k = 0; k < 4; k++) begin
            chk("st_wr", 32'(tr_wr[(t+1+k) % 1024]), 32'd1);
            chk("st_addr", tr_a[(t+1+k) % 1024], 32'h1000 + 32'(k));
        end
        chk("st_b0", 32'(tr_d[(t+1) % 1024]), 32'hEF);
        chk("st_b3", 32'(tr_d[(t+4) % 1024]), 32'hDE);
        chk("st_wr_end", 32'(tr_wr[(t+5) % 1024]), 32'd0);
        for (int k = 0; k < 4; k++) chk("st_ram", 32'(ram[13'h1000 + 13'(k)]), 32'(model_mem[13'h1000 + 13'(k)]));

        // Simultaneous requests: load/store first, fetch accepted after TURN
        t = cyc;
        exp_ls_cyc = t + 4;  exp_ls_load = 1'b1;  exp_ls_data = exp_load(32'h102, 2'b01, 1'b0);
        exp_if_cyc = t + 11; exp_if_data = exp_load(32'h1000, 2'b10, 1'b0);
        bus.ls_wr_in = 1'b0; bus.ls_size_in = 2'b01; bus.ls_signed_in = 1'b0; bus.ls_addr_in = 32'h102;
        bus.ls_req_in = 1'b1; bus.if_addr_in = 32'h1000; bus.if_req_in = 1'b1;
        seen = 1'b0;
        got_ls = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.ls_done_out) begin
                got_ls = bus.ls_rdata_out;
                bus.ls_req_in = 1'b0;
            end
            if (bus.if_done_out) begin
                got = bus.if_data_out;
                seen = 1'b1;
            end
        end
        chk("both_seen", 32'(seen), 32'd1);
        bus.if_req_in = 1'b0;
        bus.ls_req_in = 1'b0;
        @(posedge clk); #1;
        chk("both_ls_lit", got_ls, 32'h00004433);
        chk("both_if_lit", got, 32'hDEADBEEF);
        chk("both_a1", tr_a[(t+1) % 1024], 32'h102);
        chk("both_a2", tr_a[(t+2) % 1024], 32'h103);
        chk("both_gap", tr_a[(t+5) % 1024], 32'd0);
        chk("both_a6", tr_a[(t+6) % 1024], 32'h1000);
        chk("both_a9", tr_a[(t+9) % 1024], 32'h1003);

        // Stall 3 cycles after byte1 captured: byte2 re-driven, done T+10
        do_req(0, 0, 2'b10, 0, 32'h100, 0, 10, 4, 3, got, t);
        chk("stall_lit", got, 32'h44332211);
        chk("stall_a3", tr_a[(t+3) % 1024], 32'h102);
        chk("stall_redrive", tr_a[(t+7) % 1024], 32'h102);
        chk("stall_a8", tr_a[(t+8) % 1024], 32'h103);

        // Store with stall at T+2..T+3: done T+7, misaligned address
        do_req(1, 1, 2'b10, 0, 32'h1101, 32'hA1B2C3D4, 7, 2, 2, got, t);
        chk("sst_wr_stall", 32'(tr_wr[(t+2) % 1024]), 32'd0);
        chk("sst_a4", tr_a[(t+4) % 1024], 32'h1102);
        chk("sst_d4", 32'(tr_d[(t+4) % 1024]), 32'hC3);
        for (int k = 0; k < 4; k++) chk("sst_ram", 32'(ram[13'h1101 + 13'(k)]), 32'(model_mem[13'h1101 + 13'(k)]));
        do_req(1, 0, 2'b10, 0, 32'h1101, 0, 6, 0, 0, got, t);
        chk("sst_readback", got, 32'hA1B2C3D4);

        // Flush at T+2 of a fetch, then a load is accepted
        t = cyc;
        exp_if_cyc = -1;
        bus.if_addr_in = 32'h100; bus.if_req_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.if_flush_in = 1'b1; bus.if_req_in = 1'b0;
        @(posedge clk); #1;
        bus.if_flush_in = 1'b0;
        do_req(1, 0, 2'b00, 0, 32'h205, 0, 3, 0, 0, got, t);
        chk("flush_ls_lit", got, 32'h00000080);
        chk("flush_a2", tr_a[(t-1) % 1024], 32'h101);
        chk("flush_idle", tr_a[t % 1024], 32'd0);
        chk("flush_ls_a", tr_a[(t+1) % 1024], 32'h205);

        // Flush in IDLE suppresses a same-cycle fetch accept
        t = cyc;
        bus.if_addr_in = 32'h100; bus.if_req_in = 1'b1; bus.if_flush_in = 1'b1;
        @(posedge clk); #1;
        bus.if_req_in = 1'b0; bus.if_flush_in = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("idle_flush_a", tr_a[(t+1) % 1024], 32'd0);

        // Fetch wrapping past the top of the address space
        do_req(0, 0, 2'b10, 0, 32'hFFFFFFFE, 0, 6, 0, 0, got, t);
        chk("wrap_a2", tr_a[(t+2) % 1024], 32'hFFFFFFFF);
        chk("wrap_a3", tr_a[(t+3) % 1024], 32'h0);

        // Asynchronous reset aborts a store mid-flight
        chk_en = 1'b0;
        bus.ls_wr_in = 1'b1; bus.ls_size_in = 2'b10; bus.ls_addr_in = 32'h1200;
        bus.ls_wdata_in = 32'h01020304; bus.ls_req_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_wr", 32'(bus.mem_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wr", 32'(bus.mem_wr), 32'd0);
        chk("abort_a", bus.mem_a, 32'd0);
        bus.ls_req_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
CPU-side initiator for the 8-bit system memory bus. The RAM and HCI I/O blocks are the responders. It accepts instruction-fetch and load/store requests from the pipeline and splits each into sequential byte accesses on mem_a/mem_dout/mem_wr. It reassembles read bytes from mem_din, honouring rdy_in stalls, and sits inside cpu between the pipeline and the top-level bus mux.

Parameters:
ADDR_W, 32, bus address width
IO_SEL_HI, 17, upper bit of the 2-bit I/O region select (addr[17:16]==2'b11 is I/O)

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  bus ready; low = bus lent to HCI, CPU paused
if_req_in  in  1  fetch request, level, held until done
if_addr_in  in  32  fetch address
if_flush_in  in  1  abort current/pending fetch
if_done_out  out  1  one-cycle pulse, if_data_out valid
if_data_out  out  32  fetched word, little-endian
ls_req_in  in  1  load/store request, level
ls_wr_in  in  1  1 = store
ls_size_in  in  2  00 byte, 01 half, 10 word
ls_signed_in  in  1  sign-extend load
ls_addr_in  in  32  data address
ls_wdata_in  in  32  store data
ls_done_out  out  1  one-cycle pulse
ls_rdata_out  out  32  load result
mem_din  in  8  read byte, 1 cycle after address
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1 = write

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Counters 0. Asynchronous reset aborts any access immediately; a partial store may leave 1-3 bytes written.
- FSM states: IDLE, READ, WRITE, TURN.
  - IDLE -> READ/WRITE on accept.
  - READ/WRITE -> TURN when done asserts.
  - TURN -> IDLE after 1 cycle. No request is accepted in TURN.
- Accept, cycle T (IDLE):
  - ls_req_in has priority over if_req_in.
  - Address, size, signedness and wdata are latched. A fetch is always treated as size word.
- Bus idle state: mem_a=0, mem_wr=0, mem_dout=0.
- Read of N bytes (N = 1, 2 or 4):
  - Byte k address (addr+k, 32-bit wrap) is driven in cycle T+1+k.
  - mem_din is captured at the end of cycle T+2+k.
  - done and data are valid in cycle T+2+N: word = T+6, byte = T+3.
- Write of N bytes:
  - Byte k is driven in cycle T+1+k with mem_wr=1 and mem_dout = wdata[8k+7:8k].
  - done is valid in cycle T+1+N: word = T+5.
- Misaligned addresses are legal; bytes are simply sequenced. The I/O region needs no special handling.
- Load extension:
  - signed byte: sign bit 7
  - signed half: sign bit 15
  - unsigned: zero-extend
  - word: no extension
- Stall (rdy_in=0):
  - State, issue and receive counters are frozen. mem_wr is forced to 0 and captures are suppressed.
  - A write byte retires only in a cycle with rdy_in=1.
  - Read bytes whose address was driven but not yet captured are discarded: the issue index rewinds to the receive index. On the first rdy cycle that byte is re-issued.
  - A stall of S cycles during a read delays done by exactly S+1 cycles (S if no byte is in flight).
- Flush:
  - if_flush_in during a fetch (READ from the if port): return to IDLE next cycle, no if_done_out.
  - In IDLE, flush suppresses a same-cycle if_req_in accept.
  - Flush during a load/store is ignored.
- Both done pulses last exactly 1 cycle. Data outputs hold their value until the next done on the same port.

Optional Feature:
MEM_PERF_CNT_EN:
- Defined: adds ports perf_busy_out[31:0] and perf_stall_out[31:0].
  - perf_busy_out counts cycles with FSM not IDLE and rdy_in=1.
  - perf_stall_out counts cycles with FSM not IDLE and rdy_in=0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent, with identical timing.

Decomposition:
- Package mem_pkg: size encodings (SZ_B/SZ_H/SZ_W), FSM state enum, IO region select constant 2'b11, RAM_ADDR_WIDTH=17.
- Sub-module mem_load_ext: combinational byte-lane assembly plus sign/zero extension, shared by both ports.

Test Plan:
- Fetch 0x100, RAM bytes 11 22 33 44, accept at T -> mem_a 0x100..0x103 in T+1..T+4; if_data_out=0x44332211 with if_done_out at T+6.
- Load byte 0x80 at 0x205, signed -> 0xFFFFFF80; unsigned -> 0x00000080. Signed half 0x8001 -> 0xFFFF8001.
- Store word 0xDEADBEEF to 0x1000 -> mem_wr=1 for 4 cycles, bytes EF BE AD DE at 0x1000..0x1003; ls_done_out at T+5.
- if_req_in and ls_req_in asserted in the same cycle -> load/store served first. The fetch is accepted after the TURN cycle; no overlap on mem_a.
- rdy_in low for 3 cycles after byte1 of a word read is captured -> byte2 address re-driven and correct word returned; done at T+6+4. During a store, no mem_wr=1 while rdy_in=0.
- if_flush_in at T+2 of a fetch -> no if_done_out; bus idle next cycle. A following ls_req_in is accepted.
